// File: rtl/weight_instr_dispatcher.sv
// Weight instruction dispatcher: queues weight instructions and hands them one at a time
// to the weight flow controller, dropping zero-length entries and timing out lost acks.
package weight_instr_dispatcher_pkg;
   typedef struct packed {
      logic [7:0]  opcode;
      logic [31:0] length;
      logic [39:0] weight_addr;
   } weight_instr_type;
endpackage

module weight_instr_dispatcher
   import weight_instr_dispatcher_pkg::*;
#(
   parameter int FIFO_DEPTH  = 4,
   parameter int ACK_TIMEOUT = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          enable,
   input  weight_instr_type              in_instr,
   input  logic                          in_valid,
   output logic                          in_ready,
   output weight_instr_type              out_instr,
   output logic                          out_instr_enable,
   input  logic                          ctrl_busy,
   input  logic                          ctrl_resource_busy,
   output logic [$clog2(FIFO_DEPTH):0]   pending,
   output logic                          idle,
   output logic                          dropped,
   output logic                          timeout_err
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int TW = $clog2(ACK_TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ACK, WAIT_DONE} state_t;

   state_t           state;
   weight_instr_type mem [FIFO_DEPTH];
   weight_instr_type head;
   logic [AW-1:0]    wr_ptr, rd_ptr;
   logic [AW:0]      count;
   logic [TW-1:0]    to_cnt;
   logic             push, pop, empty, full;

   assign empty    = (count == '0);
   assign full     = (count == (AW+1)'(FIFO_DEPTH));
   assign in_ready = !full;
   assign pending  = count;
   assign idle     = (state == IDLE) && empty;
   assign head     = mem[rd_ptr];
   assign push     = in_valid && !full;
   // Zero-length heads are discarded regardless of controller state.
   assign pop      = (state == IDLE) && enable && !empty &&
                     ((head.length == '0) || (!ctrl_busy && !ctrl_resource_busy));

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= in_instr;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state            <= IDLE;
         out_instr        <= '0;
         out_instr_enable <= 1'b0;
         dropped          <= 1'b0;
         timeout_err      <= 1'b0;
         to_cnt           <= '0;
      end else begin
         out_instr_enable <= 1'b0;
         dropped          <= 1'b0;
         timeout_err      <= 1'b0;
         case (state)
            IDLE: begin
               if (pop) begin
                  if (head.length == '0) begin
                     dropped <= 1'b1;
                  end else begin
                     out_instr        <= head;
                     out_instr_enable <= 1'b1;
                     state            <= ISSUE;
                  end
               end
            end
            ISSUE: begin
               to_cnt <= '0;
               state  <= WAIT_ACK;
            end
            WAIT_ACK: begin
               if (ctrl_busy) begin
                  state <= WAIT_DONE;
               end else if (to_cnt == TW'(ACK_TIMEOUT - 1)) begin
                  state       <= IDLE;
                  timeout_err <= 1'b1;
               end else begin
                  to_cnt <= to_cnt + TW'(1);
               end
            end
            WAIT_DONE: begin
               if (!ctrl_busy) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_weight_instr_dispatcher.sv
// Bench for weight_instr_dispatcher: transaction-level queue model plus a behavioural
// weight flow controller that acks, stalls or ignores each issued instruction.
module tb_weight_instr_dispatcher;
   import weight_instr_dispatcher_pkg::*;
   localparam int DEPTH = 4;
   localparam int TO    = 4;
   localparam int PW    = $clog2(DEPTH) + 1;

   logic clk = 1'b0, rst = 1'b1, enable = 1'b0, in_valid = 1'b0;
   logic ctrl_busy = 1'b0, ctrl_resource_busy = 1'b0;
   weight_instr_type in_instr = '0;
   weight_instr_type out_instr;
   logic in_ready, out_instr_enable, idle, dropped, timeout_err;
   logic [PW-1:0] pending;

   int tests = 0, fails = 0;
   weight_instr_type q[$];
   weight_instr_type issued[$];
   weight_instr_type last_iss = '0;
   weight_instr_type blk [4];
   int cyc = 0, to_cyc = -1, busy_s = -1, busy_e = -1, earliest = 0;
   int ack_mode = 1, n_drop = 0, n_to = 0, n0 = 0, d0 = 0;
   logic force_busy = 1'b0;

   always #5 clk = ~clk;

   weight_instr_dispatcher #(.FIFO_DEPTH(DEPTH), .ACK_TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst), .enable(enable), .in_instr(in_instr), .in_valid(in_valid),
      .in_ready(in_ready), .out_instr(out_instr), .out_instr_enable(out_instr_enable),
      .ctrl_busy(ctrl_busy), .ctrl_resource_busy(ctrl_resource_busy), .pending(pending),
      .idle(idle), .dropped(dropped), .timeout_err(timeout_err)
   );

   task automatic chk(input string tag, input logic [79:0] act, input logic [79:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   function automatic weight_instr_type mk(input logic [7:0] op, input logic [31:0] len,
                                           input logic [39:0] a);
      weight_instr_type w;
      w.opcode = op; w.length = len; w.weight_addr = a;
      return w;
   endfunction

   task automatic drive_busy();
      ctrl_busy = force_busy || (cyc >= busy_s && cyc < busy_e);
   endtask

   // Controller reaction to an issue seen in cycle s; also fixes when the dispatcher may issue again.
   task automatic schedule(input int s);
      int d, len;
      bit ack;
      d = 0; len = 1; ack = 1'b1;
      case (ack_mode)
         1: begin ack = 1'b1; d = 0; len = 1; end
         2: ack = 1'b0;
         3: begin ack = 1'b1; d = 0; len = 60; end
         default: begin
            ack = ($urandom_range(0, 3) != 0);
            d   = $urandom_range(0, TO - 1);
            len = $urandom_range(1, 4);
         end
      endcase
      if (ack) begin
         busy_s = s + 1 + d; busy_e = busy_s + len; to_cyc = -1; earliest = busy_e + 2;
      end else begin
         busy_s = -1; busy_e = -1; to_cyc = s + TO + 1; earliest = s + TO + 2;
      end
   endtask

   task automatic step();
      logic pv, pe, pb, pr, prst, pushed;
      weight_instr_type pi, h;
      pv = in_valid; pi = in_instr; pe = enable; pb = ctrl_busy; pr = ctrl_resource_busy; prst = rst;
      @(posedge clk); #1; cyc++;
      pushed = pv && prst && rst && (q.size() < DEPTH);
      chk("one_pop", 80'(out_instr_enable && dropped), 80'(0));
      if (out_instr_enable || dropped) begin
         chk("pop_nonempty", 80'(q.size() != 0), 80'(1));
         if (q.size() != 0) begin
            h = q.pop_front();
            if (out_instr_enable) begin
               chk("issue_instr", out_instr, h);
               chk("issue_len", 80'(h.length != 0), 80'(1));
               chk("issue_gate", {pe, pb, pr}, 3'b100);
               chk("issue_spacing", 80'(cyc >= earliest), 80'(1));
               last_iss = h;
               issued.push_back(h);
               schedule(cyc);
            end else begin
               chk("drop_len", 80'(h.length == 0), 80'(1));
               chk("drop_gate", pe, 1'b1);
               chk("drop_spacing", 80'(cyc >= earliest), 80'(1));
               n_drop++;
            end
         end
      end
      if (pushed) q.push_back(pi);
      chk("pending", pending, 80'(q.size()));
      chk("in_ready", in_ready, 80'(q.size() < DEPTH));
      chk("out_hold", out_instr, last_iss);
      chk("timeout_err", timeout_err, 80'(cyc == to_cyc));
      if (cyc == to_cyc) n_to++;
      chk("idle", idle, 80'(q.size() == 0 && cyc >= earliest - 1));
      drive_busy();
   endtask

   task automatic push1(input weight_instr_type w);
      in_valid = 1'b1; in_instr = w;
      step();
      in_valid = 1'b0;
   endtask

   task automatic wait_strobe();
      int n = 0;
      while (!out_instr_enable && n < 20) begin step(); n++; end
      chk("wait_strobe", out_instr_enable, 1'b1);
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_pending"}, pending, 80'(0));
      chk({tag, "_out_instr"}, out_instr, 80'(0));
      chk({tag, "_strobe"}, out_instr_enable, 1'b0);
      chk({tag, "_dropped"}, dropped, 1'b0);
      chk({tag, "_timeout"}, timeout_err, 1'b0);
      chk({tag, "_idle"}, idle, 1'b1);
      chk({tag, "_in_ready"}, in_ready, 1'b1);
   endtask

   task automatic do_reset();
      #2 rst = 1'b0;
      #1 chk_reset("rst_async");
      q.delete(); to_cyc = -1; busy_s = -1; busy_e = -1; earliest = 0; last_iss = '0;
      force_busy = 1'b0; in_valid = 1'b0;
      drive_busy();
      repeat (2) step();
      chk_reset("rst_held");
      rst = 1'b1;
   endtask

   initial begin
      #2 rst = 1'b0;
      #1 chk_reset("por");
      repeat (2) step();
      rst = 1'b1;
      enable = 1'b1; ack_mode = 1;
      repeat (2) step();

      // single issue latency
      push1(mk(8'h09, 32'd15, 40'h21));
      chk("lat_n", out_instr_enable, 1'b0);
      chk("lat_pend1", pending, 80'(1));
      step();
      chk("lat_n1", out_instr_enable, 1'b1);
      chk("lat_instr", out_instr, mk(8'h09, 32'd15, 40'h21));
      chk("lat_pend0", pending, 80'(0));
      step();
      chk("strobe_1cyc", out_instr_enable, 1'b0);
      repeat (6) step();

      // fill while controller busy, then drain in order
      force_busy = 1'b1; drive_busy(); n0 = issued.size();
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1;
         in_instr = mk(8'(8'h10 + i), 32'(100 + i), 40'(40'h1000 + i));
         if (i < 4) blk[i] = in_instr;
         step();
         if (i == 3) begin
            chk("full_ready", in_ready, 1'b0);
            chk("full_pend", pending, 80'(4));
         end
      end
      in_valid = 1'b0;
      chk("full_pend5", pending, 80'(4));
      chk("busy_no_issue", 80'(issued.size() - n0), 80'(0));
      force_busy = 1'b0; drive_busy();
      repeat (30) step();
      chk("drain_cnt", 80'(issued.size() - n0), 80'(4));
      for (int i = 0; i < 4; i++)
         if (n0 + i < issued.size()) chk("drain_order", issued[n0+i], blk[i]);

      // zero-length drop
      d0 = n_drop; n0 = issued.size();
      push1(mk(8'h01, 32'd0, 40'h5));
      push1(mk(8'h02, 32'd14, 40'h6));
      repeat (8) step();
      chk("drop_cnt", 80'(n_drop - d0), 80'(1));
      chk("drop_issue_cnt", 80'(issued.size() - n0), 80'(1));
      chk("drop_issue_len", issued[issued.size()-1].length, 80'(14));

      // ack timeout
      ack_mode = 2;
      push1(mk(8'h03, 32'd7, 40'h7));
      wait_strobe();
      repeat (TO) begin step(); chk("to_wait", timeout_err, 1'b0); end
      step();
      chk("to_pulse", timeout_err, 1'b1);
      chk("to_idle", idle, 1'b1);
      ack_mode = 1; n0 = issued.size();
      push1(mk(8'h04, 32'd8, 40'h8));
      wait_strobe();
      chk("to_next_issue", 80'(issued.size() - n0), 80'(1));
      repeat (8) step();

      // resource busy and enable gating
      ctrl_resource_busy = 1'b1; n0 = issued.size();
      push1(mk(8'h05, 32'd9, 40'h9));
      repeat (6) step();
      chk("res_block", 80'(issued.size() - n0), 80'(0));
      ctrl_resource_busy = 1'b0;
      repeat (3) step();
      chk("res_release", 80'(issued.size() - n0), 80'(1));
      repeat (4) step();
      enable = 1'b0; n0 = issued.size();
      push1(mk(8'h06, 32'd10, 40'hA));
      repeat (6) step();
      chk("en_block", 80'(issued.size() - n0), 80'(0));
      enable = 1'b1;
      repeat (3) step();
      chk("en_release", 80'(issued.size() - n0), 80'(1));
      repeat (4) step();

      // reset while waiting for the controller with a backlog
      ack_mode = 3;
      push1(mk(8'h07, 32'd11, 40'hB));
      wait_strobe();
      for (int i = 0; i < 3; i++) push1(mk(8'(8'h20 + i), 32'(20 + i), 40'(40'hC0 + i)));
      repeat (2) step();
      chk("wd_pend3", pending, 80'(3));
      do_reset();
      ack_mode = 1; n0 = issued.size();
      repeat (10) step();
      chk("post_rst_no_issue", 80'(issued.size() - n0), 80'(0));

      // randomized traffic
      ack_mode = 0;
      for (int i = 0; i < 2000; i++) begin
         in_valid = ($urandom_range(0, 1) != 0);
         in_instr = mk(8'($urandom), ($urandom_range(0, 5) == 0) ? 32'd0 : 32'($urandom_range(1, 1000)),
                       {8'($urandom), 32'($urandom)});
         enable = ($urandom_range(0, 9) != 0);
         ctrl_resource_busy = ($urandom_range(0, 7) == 0);
         step();
      end
      in_valid = 1'b0; enable = 1'b1; ctrl_resource_busy = 1'b0;
      repeat (60) step();
      chk("final_drain", pending, 80'(0));
      chk("saw_timeouts", 80'(n_to > 1), 80'(1));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/weight_instr_dispatcher.md
WEIGHT_INSTR_DISPATCHER -- requirements
Module: weight_instr_dispatcher

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, instruction queue depth (power of two, >=2).
REQ-002 SHALL have parameter ACK_TIMEOUT, default 4, max cycles waiting for controller busy after issue.
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous active-low reset.
REQ-005 SHALL have port enable  input  1  permits new issues.
REQ-006 SHALL have port in_instr  input  weight_instr_type (opcode 8, length 32, weight_addr 40)  instruction to queue.
REQ-007 SHALL have port in_valid  input  1  in_instr valid.
REQ-008 SHALL have port in_ready  output  1  queue can accept (= not full).
REQ-009 SHALL have port out_instr  output  weight_instr_type  instruction to weight flow controller.
REQ-010 SHALL have port out_instr_enable  output  1  one-cycle issue strobe.
REQ-011 SHALL have port ctrl_busy  input  1  weight flow controller busy.
REQ-012 SHALL have port ctrl_resource_busy  input  1  weight flow controller resource busy.
REQ-013 SHALL have port pending  output  $clog2(FIFO_DEPTH)+1  queued instruction count.
REQ-014 SHALL have port idle  output  1  state IDLE and queue empty.
REQ-015 SHALL have port dropped  output  1  one-cycle pulse, zero-length instruction discarded.
REQ-016 SHALL have port timeout_err  output  1  one-cycle pulse, controller never went busy.

Function
REQ-017 SHALL push in_instr into FIFO on in_valid && in_ready; no push when full, even if pop same cycle.
REQ-018 SHALL keep pending unchanged on simultaneous push and pop; head of a previously empty FIFO visible no earlier than cycle after push (no bypass).
REQ-019 SHALL implement FSM states IDLE, ISSUE, WAIT_ACK, WAIT_DONE.
REQ-020 IDLE: if enable, FIFO non-empty, head length==0 -> pop, pulse dropped next cycle, stay IDLE.
REQ-021 IDLE: if enable, FIFO non-empty, head length!=0, ctrl_busy==0, ctrl_resource_busy==0 -> load out_instr from head, pop, go ISSUE.
REQ-022 ISSUE: out_instr_enable=1 for exactly this cycle; go WAIT_ACK; clear timeout counter.
REQ-023 WAIT_ACK: ctrl_busy==1 -> WAIT_DONE; else after ACK_TIMEOUT cycles -> IDLE with timeout_err pulse.
REQ-024 WAIT_DONE: ctrl_busy==0 -> IDLE; stays indefinitely otherwise.
REQ-025 out_instr SHALL hold last issued instruction until next issue.
REQ-026 enable low SHALL block IDLE exits only; ISSUE/WAIT states complete; pushes continue.
REQ-027 Latency: push at edge N into empty FIFO, controller idle, enable=1 -> out_instr_enable high in cycle N+2.
REQ-028 At most one instruction outstanding at the controller at any time.

Reset
REQ-029 rst low SHALL immediately: state IDLE, FIFO emptied, pending 0, out_instr all-zero, out_instr_enable 0, dropped 0, timeout_err 0, idle 1, in_ready 1.
REQ-030 Reset mid-operation SHALL discard queued and in-flight instructions; no issue strobe until FIFO refilled after release.

Verification
REQ-031 Push {opcode 0x09, length 15, addr 0x21}, ctrl idle -> out_instr_enable pulse 2 cycles later, out_instr matches, pending 1->0.
REQ-032 Push 5 instructions back-to-back with ctrl_busy held 1 -> in_ready low after 4th, pending 4, no strobe; release busy -> issues in FIFO order, one per busy cycle.
REQ-033 Push length 0 then length 14 -> dropped pulse once, only length-14 issued.
REQ-034 Issue with ctrl_busy never rising -> timeout_err pulse after 4 WAIT_ACK cycles, FSM back to IDLE, next instruction issued.
REQ-035 ctrl_resource_busy=1 with queued instruction -> no strobe until it drops; enable=0 likewise blocks issue.
REQ-036 Assert rst in WAIT_DONE with 3 queued -> outputs at reset values asynchronously, pending 0, no strobe after release.
